// File: rtl/cpu7_intr_ctl.sv
// cpu7_intr_ctl: interrupt controller for the CSR exception-entry path.
// Owns ECFG.LIE and ESTAT.IS, picks the highest-index enabled pending source
// and hands it to ecl with a req/ack handshake. After an accepted interrupt,
// new requests stay blocked until CRMD.IE has been seen low.
// Optional build macro: INTR_SYNC_EN adds a 2-flop synchronizer on ext_intr
// and ipi_intr ahead of ESTAT.IS.
`ifndef LSOC1K_CSR_BIT
`define LSOC1K_CSR_BIT 14
`endif
`ifndef GRLEN
`define GRLEN 32
`endif

module cpu7_intr_ctl #(
  parameter logic [`LSOC1K_CSR_BIT-1:0] ECFG_ADDR  = 14'h4,
  parameter logic [`LSOC1K_CSR_BIT-1:0] ESTAT_ADDR = 14'h5,
  parameter int unsigned                IS_W       = 13
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [7:0]                 ext_intr,
  input  logic                       ipi_intr,
  input  logic                       timer_pend,
  input  logic                       crmd_ie,
  input  logic                       csr_wen,
  input  logic [`LSOC1K_CSR_BIT-1:0] csr_waddr,
  input  logic [`GRLEN-1:0]          csr_wdata,
  input  logic [`GRLEN-1:0]          csr_mask,
  input  logic [`LSOC1K_CSR_BIT-1:0] csr_raddr,
  output logic [`GRLEN-1:0]          intr_rdata,
  input  logic                       ecl_intr_ack,
  output logic                       intr_req,
  output logic [3:0]                 intr_vec,
  output logic                       intr_taken
);

  localparam int unsigned GRLEN_W = `GRLEN;
  // Bit 10 of LIE/IS is reserved and never holds a 1.
  localparam logic [IS_W-1:0] LIE_MASK = ~(IS_W'(1) << 10);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    TAKEN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IS_W-1:0] lie_q, lie_d;
  logic [IS_W-1:0] is_q, is_d;
  logic [3:0]      intr_vec_q, intr_vec_d;
  logic            intr_req_q, intr_req_d;
  logic            intr_taken_q, intr_taken_d;

  logic [7:0]      ext_s;
  logic            ipi_s;
  logic [IS_W-1:0] pend_c;
  logic            elig_c;
  logic [3:0]      win_c;
  logic            ecfg_we_c, estat_we_c;

  logic unused_bits;
  assign unused_bits = ^{csr_wdata[GRLEN_W-1:IS_W], csr_mask[GRLEN_W-1:IS_W]};

`ifdef INTR_SYNC_EN
  logic [7:0] ext_s1_q, ext_s2_q;
  logic       ipi_s1_q, ipi_s2_q;

  // Two-stage synchronizer for the asynchronous interrupt lines.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ext_s1_q <= '0;
      ext_s2_q <= '0;
      ipi_s1_q <= 1'b0;
      ipi_s2_q <= 1'b0;
    end else begin
      ext_s1_q <= ext_intr;
      ext_s2_q <= ext_s1_q;
      ipi_s1_q <= ipi_intr;
      ipi_s2_q <= ipi_s1_q;
    end
  end

  assign ext_s = ext_s2_q;
  assign ipi_s = ipi_s2_q;
`else
  assign ext_s = ext_intr;
  assign ipi_s = ipi_intr;
`endif

  assign ecfg_we_c  = csr_wen && (csr_waddr == ECFG_ADDR);
  assign estat_we_c = csr_wen && (csr_waddr == ESTAT_ADDR);

  // Next LIE/IS: masked software writes plus per-cycle source sampling.
  always_comb begin
    lie_d = lie_q;
    if (ecfg_we_c) begin
      lie_d = ((lie_q & ~csr_mask[IS_W-1:0]) | (csr_wdata[IS_W-1:0] & csr_mask[IS_W-1:0]))
              & LIE_MASK;
    end
    is_d       = '0;
    is_d[1:0]  = is_q[1:0];
    if (estat_we_c) begin
      is_d[1:0] = (is_q[1:0] & ~csr_mask[1:0]) | (csr_wdata[1:0] & csr_mask[1:0]);
    end
    is_d[9:2]  = ext_s;
    is_d[11]   = timer_pend;
    is_d[12]   = ipi_s;
  end

  // CSR state registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lie_q <= '0;
      is_q  <= '0;
    end else begin
      lie_q <= lie_d;
      is_q  <= is_d;
    end
  end

  assign pend_c = is_q & lie_q;
  assign elig_c = (|pend_c) && crmd_ie;

  // Fixed priority: highest set index of the pending vector wins.
  always_comb begin
    win_c = '0;
    for (int i = 0; i < IS_W; i++) begin
      if (pend_c[i]) win_c = 4'(i);
    end
  end

  // Read mux; reflects register state before any same-cycle write.
  always_comb begin
    intr_rdata = '0;
    if (csr_raddr == ECFG_ADDR) begin
      intr_rdata = GRLEN_W'(lie_q);
    end else if (csr_raddr == ESTAT_ADDR) begin
      intr_rdata = GRLEN_W'(is_q);
    end
  end

  // Handshake FSM next state and registered-output next values.
  always_comb begin
    state_d    = state_q;
    intr_vec_d = intr_vec_q;
    unique case (state_q)
      IDLE: begin
        if (elig_c) begin
          state_d    = REQ;
          intr_vec_d = win_c;
        end
      end
      REQ: begin
        if (ecl_intr_ack) begin
          state_d = TAKEN;
        end else if (elig_c) begin
          intr_vec_d = win_c;
        end else begin
          state_d = IDLE;
        end
      end
      TAKEN: state_d = HOLD;
      HOLD: begin
        if (!crmd_ie) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    intr_req_d   = (state_d == REQ);
    intr_taken_d = (state_d == TAKEN);
  end

  // FSM state and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      intr_vec_q   <= '0;
      intr_req_q   <= 1'b0;
      intr_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      intr_vec_q   <= intr_vec_d;
      intr_req_q   <= intr_req_d;
      intr_taken_q <= intr_taken_d;
    end
  end

  assign intr_req   = intr_req_q;
  assign intr_vec   = intr_vec_q;
  assign intr_taken = intr_taken_q;

endmodule

// File: tb/tb_cpu7_intr_ctl.sv
// Bench for cpu7_intr_ctl: directed vector table, hand sequences for the
// handshake corner cases, then randomized traffic against a reference model.
module tb_cpu7_intr_ctl;

  localparam logic [13:0] ECFG  = 14'h4;
  localparam logic [13:0] ESTAT = 14'h5;
`ifdef INTR_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  ext_intr;
  logic        ipi_intr, timer_pend, crmd_ie, csr_wen, ecl_intr_ack;
  logic [13:0] csr_waddr, csr_raddr;
  logic [31:0] csr_wdata, csr_mask, intr_rdata;
  logic        intr_req, intr_taken;
  logic [3:0]  intr_vec;

  always #5 clk = ~clk;

  cpu7_intr_ctl dut (
    .clk          (clk),
    .resetn       (resetn),
    .ext_intr     (ext_intr),
    .ipi_intr     (ipi_intr),
    .timer_pend   (timer_pend),
    .crmd_ie      (crmd_ie),
    .csr_wen      (csr_wen),
    .csr_waddr    (csr_waddr),
    .csr_wdata    (csr_wdata),
    .csr_mask     (csr_mask),
    .csr_raddr    (csr_raddr),
    .intr_rdata   (intr_rdata),
    .ecl_intr_ack (ecl_intr_ack),
    .intr_req     (intr_req),
    .intr_vec     (intr_vec),
    .intr_taken   (intr_taken)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  // Reference model state: register contents plus handshake flags.
  int m_lie, m_is, m_vec;
  bit m_req, m_blk, m_tk;
  int m_e1, m_e2;
  bit m_i1, m_i2;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic int top_index(input int v);
    int r = 0;
    for (int i = 0; i < 13; i++) if (((v >> i) & 1) != 0) r = i;
    return r;
  endfunction

  function automatic int model_rd(input logic [13:0] a);
    if (a == ECFG) return m_lie;
    if (a == ESTAT) return m_is;
    return 0;
  endfunction

  // Advance the model by one clock edge using the inputs held this cycle.
  task automatic model_step();
    int  pend, wd, mk, sw, es, is_ipi;
    bit  elig;
    int  nlie, nis, nvec;
    bit  nreq, nblk, ntk;
    if (!resetn) begin
      m_lie = 0; m_is = 0; m_vec = 0; m_req = 0; m_blk = 0; m_tk = 0;
      m_e1 = 0; m_e2 = 0; m_i1 = 0; m_i2 = 0;
      return;
    end
    pend = m_is & m_lie;
    elig = (pend != 0) && crmd_ie;
    wd   = int'(csr_wdata);
    mk   = int'(csr_mask);
    nlie = m_lie;
    if (csr_wen && csr_waddr == ECFG) nlie = ((m_lie & ~mk) | (wd & mk)) & 'h1BFF;
    sw = m_is & 3;
    if (csr_wen && csr_waddr == ESTAT) sw = ((sw & ~mk) | (wd & mk)) & 3;
    es     = (SYNC_LAT != 0) ? m_e2 : int'(ext_intr);
    is_ipi = (SYNC_LAT != 0) ? int'(m_i2) : int'(ipi_intr);
    nis = sw | (es << 2) | (int'(timer_pend) << 11) | (is_ipi << 12);
    nreq = m_req; nblk = m_blk; nvec = m_vec;
    ntk  = m_req && ecl_intr_ack;
    if (m_req) begin
      if (ecl_intr_ack) begin nreq = 0; nblk = 1; end
      else if (elig) nvec = top_index(pend);
      else nreq = 0;
    end else if (m_blk) begin
      if (!m_tk && !crmd_ie) nblk = 0;
    end else if (elig) begin
      nreq = 1; nvec = top_index(pend);
    end
    m_e2 = m_e1; m_e1 = int'(ext_intr);
    m_i2 = m_i1; m_i1 = ipi_intr;
    m_lie = nlie; m_is = nis; m_vec = nvec;
    m_req = nreq; m_blk = nblk; m_tk = ntk;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (cmp_en) begin
      check("rnd_req", 32'(intr_req), 32'(m_req));
      check("rnd_vec", 32'(intr_vec), 32'(m_vec));
      check("rnd_taken", 32'(intr_taken), 32'(m_tk));
      check("rnd_rdata", intr_rdata, 32'(model_rd(csr_raddr)));
    end
  endtask

  task automatic idle_inputs();
    ext_intr = '0; ipi_intr = 0; timer_pend = 0; crmd_ie = 0; csr_wen = 0;
    csr_waddr = '0; csr_wdata = '0; csr_mask = '0; csr_raddr = ECFG; ecl_intr_ack = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    idle_inputs();
    tick();
    tick();
    resetn = 1;
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
    csr_wen = 1; csr_waddr = a; csr_wdata = d; csr_mask = m;
  endtask

  typedef struct {
    logic        wen;
    logic [13:0] waddr;
    logic [31:0] wdata;
    logic [31:0] mask;
    logic        timer;
    logic        ie;
    logic        ack;
    logic [13:0] raddr;
    logic        e_req;
    logic [3:0]  e_vec;
    logic        e_tk;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // Timer-driven handshake, HOLD/IE release, software IS bits.
    tbl[0]  = '{1'b1, ECFG,  32'h800,  32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, ECFG,  1'b0, 4'd0,  1'b0, 32'h800};
    tbl[1]  = '{1'b0, ECFG,  32'h0,    32'h0,         1'b1, 1'b1, 1'b0, ESTAT, 1'b0, 4'd0,  1'b0, 32'h800};
    tbl[2]  = '{1'b0, ECFG,  32'h0,    32'h0,         1'b1, 1'b1, 1'b0, ESTAT, 1'b1, 4'd11, 1'b0, 32'h800};
    tbl[3]  = '{1'b0, ECFG,  32'h0,    32'h0,         1'b1, 1'b1, 1'b0, ESTAT, 1'b1, 4'd11, 1'b0, 32'h800};
    tbl[4]  = '{1'b0, ECFG,  32'h0,    32'h0,         1'b1, 1'b1, 1'b1, ESTAT, 1'b0, 4'd11, 1'b1, 32'h800};
    tbl[5]  = '{1'b0, ECFG,  32'h0,    32'h0,         1'b1, 1'b1, 1'b0, ESTAT, 1'b0, 4'd11, 1'b0, 32'h800};
    tbl[6]  = '{1'b0, ECFG,  32'h0,    32'h0,         1'b1, 1'b1, 1'b0, ESTAT, 1'b0, 4'd11, 1'b0, 32'h800};
    tbl[7]  = '{1'b0, ECFG,  32'h0,    32'h0,         1'b1, 1'b0, 1'b0, ESTAT, 1'b0, 4'd11, 1'b0, 32'h800};
    tbl[8]  = '{1'b0, ECFG,  32'h0,    32'h0,         1'b1, 1'b1, 1'b0, ESTAT, 1'b1, 4'd11, 1'b0, 32'h800};
    tbl[9]  = '{1'b0, ECFG,  32'h0,    32'h0,         1'b0, 1'b1, 1'b0, ESTAT, 1'b1, 4'd11, 1'b0, 32'h0};
    tbl[10] = '{1'b0, ECFG,  32'h0,    32'h0,         1'b0, 1'b1, 1'b0, 14'h6, 1'b0, 4'd11, 1'b0, 32'h0};
    tbl[11] = '{1'b1, ECFG,  32'h1,    32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, ECFG,  1'b0, 4'd11, 1'b0, 32'h1};
    tbl[12] = '{1'b1, ESTAT, 32'h3,    32'h1,         1'b0, 1'b1, 1'b0, ESTAT, 1'b0, 4'd11, 1'b0, 32'h1};
    tbl[13] = '{1'b0, ECFG,  32'h0,    32'h0,         1'b0, 1'b1, 1'b0, ESTAT, 1'b1, 4'd0,  1'b0, 32'h1};
    tbl[14] = '{1'b1, ESTAT, 32'h1FFC, 32'h1FFC,      1'b0, 1'b1, 1'b0, ESTAT, 1'b1, 4'd0,  1'b0, 32'h1};
    tbl[15] = '{1'b0, ECFG,  32'h0,    32'h0,         1'b0, 1'b1, 1'b1, ESTAT, 1'b0, 4'd0,  1'b1, 32'h1};

    do_reset();
    check("reset_req", 32'(intr_req), 32'h0);
    check("reset_vec", 32'(intr_vec), 32'h0);
    check("reset_taken", 32'(intr_taken), 32'h0);
    check("reset_ecfg", intr_rdata, 32'h0);

    for (int r = 0; r < 16; r++) begin
      csr_wen = tbl[r].wen; csr_waddr = tbl[r].waddr;
      csr_wdata = tbl[r].wdata; csr_mask = tbl[r].mask;
      timer_pend = tbl[r].timer; crmd_ie = tbl[r].ie;
      ecl_intr_ack = tbl[r].ack; csr_raddr = tbl[r].raddr;
      tick();
      check($sformatf("tbl%0d_req", r), 32'(intr_req), 32'(tbl[r].e_req));
      check($sformatf("tbl%0d_vec", r), 32'(intr_vec), 32'(tbl[r].e_vec));
      check($sformatf("tbl%0d_taken", r), 32'(intr_taken), 32'(tbl[r].e_tk));
      check($sformatf("tbl%0d_rdata", r), intr_rdata, tbl[r].e_rd);
    end

    // Priority: ipi beats ext; dropping ipi re-targets the live request.
    do_reset();
    csr_write(ECFG, 32'h1FFF, 32'hFFFF_FFFF);
    ext_intr = 8'h01; ipi_intr = 1; crmd_ie = 1;
    tick();
    csr_wen = 0;
    repeat (SYNC_LAT) tick();
    tick();
    check("prio_req", 32'(intr_req), 32'h1);
    check("prio_vec12", 32'(intr_vec), 32'd12);
    ipi_intr = 0;
    tick();
    check("prio_hold_vec12", 32'(intr_vec), 32'd12);
    repeat (SYNC_LAT) tick();
    tick();
    check("prio_req_kept", 32'(intr_req), 32'h1);
    check("prio_vec2", 32'(intr_vec), 32'd2);

    // Withdrawal by clearing LIE without ack: request drops, no taken.
    csr_write(ECFG, 32'h0, 32'hFFFF_FFFF);
    tick();
    csr_wen = 0;
    check("wd_req_still", 32'(intr_req), 32'h1);
    tick();
    check("wd_req_drop", 32'(intr_req), 32'h0);
    check("wd_no_taken", 32'(intr_taken), 32'h0);
    tick();
    check("wd_no_taken2", 32'(intr_taken), 32'h0);

    // Ack in the same cycle as the withdrawing LIE write: ack wins.
    csr_write(ECFG, 32'h1FFF, 32'hFFFF_FFFF);
    tick();
    csr_wen = 0;
    tick();
    check("ackwin_req", 32'(intr_req), 32'h1);
    csr_write(ECFG, 32'h0, 32'hFFFF_FFFF);
    ecl_intr_ack = 1;
    tick();
    csr_wen = 0; ecl_intr_ack = 0;
    check("ackwin_taken", 32'(intr_taken), 32'h1);
    check("ackwin_req0", 32'(intr_req), 32'h0);
    check("ackwin_vec", 32'(intr_vec), 32'd2);

    // HOLD: source pending and enabled, IE still 1 -> no new request.
    csr_write(ECFG, 32'h1FFF, 32'hFFFF_FFFF);
    ecl_intr_ack = 1;
    tick();
    csr_wen = 0; ecl_intr_ack = 0;
    tick();
    tick();
    check("hold_req0", 32'(intr_req), 32'h0);
    check("hold_taken0", 32'(intr_taken), 32'h0);

    // IE low releases HOLD, then reset in the middle of REQ.
    crmd_ie = 0;
    tick();
    crmd_ie = 1;
    tick();
    check("rel_req", 32'(intr_req), 32'h1);
    resetn = 0;
    ecl_intr_ack = 1;
    tick();
    check("rst_req0", 32'(intr_req), 32'h0);
    check("rst_vec0", 32'(intr_vec), 32'h0);
    check("rst_taken0", 32'(intr_taken), 32'h0);
    check("rst_lie0", intr_rdata, 32'h0);
    resetn = 1;
    ecl_intr_ack = 0;
    tick();
    check("rst_no_taken", 32'(intr_taken), 32'h0);

`ifdef INTR_SYNC_EN
    // Synchronizer latency: edge at N, IS at N+3, request at N+4.
    do_reset();
    csr_write(ECFG, 32'h200, 32'hFFFF_FFFF);
    crmd_ie = 1;
    tick();
    csr_wen = 0;
    csr_raddr = ESTAT;
    ext_intr = 8'h80;
    tick();
    tick();
    check("sync_is_n2", intr_rdata, 32'h0);
    tick();
    check("sync_is_n3", intr_rdata, 32'h200);
    check("sync_req_n3", 32'(intr_req), 32'h0);
    tick();
    check("sync_req_n4", 32'(intr_req), 32'h1);
    check("sync_vec_n4", 32'(intr_vec), 32'd9);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    cmp_en = 1;
    for (int c = 0; c < 3000; c++) begin
      resetn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 7) == 0) ext_intr = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 9) == 0) ipi_intr = ~ipi_intr;
      if ($urandom_range(0, 9) == 0) timer_pend = ~timer_pend;
      if ($urandom_range(0, 5) == 0) crmd_ie = ~crmd_ie;
      ecl_intr_ack = ($urandom_range(0, 3) == 0);
      csr_wen = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 2))
        0: csr_waddr = ECFG;
        1: csr_waddr = ESTAT;
        default: csr_waddr = 14'h9;
      endcase
      csr_wdata = $urandom;
      csr_mask  = $urandom;
      case ($urandom_range(0, 2))
        0: csr_raddr = ECFG;
        1: csr_raddr = ESTAT;
        default: csr_raddr = 14'h3;
      endcase
      tick();
    end
    cmp_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu7_intr_ctl.md
Name: cpu7_intr_ctl

Overview:
- Interrupt controller/scheduler for the CSR block's exception-entry datapath.
- Owns the ECFG.LIE and ESTAT.IS state and samples hardware, IPI and timer interrupt levels.
- Arbitrates the enabled pending sources by fixed priority and presents one interrupt request to ecl through a req/ack handshake.
- On ack it reports the winning vector. It then blocks new requests until the CSR side has cleared CRMD.IE, so one interrupt drives one exception entry.

Parameters:
- ECFG_ADDR, 14'h4, CSR address of ECFG.
- ESTAT_ADDR, 14'h5, CSR address of ESTAT.
- IS_W, 13, width of LIE/IS fields. Bit 10 is reserved and always reads 0.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- ext_intr  in  8  hardware interrupt levels, mapped to IS[9:2]
- ipi_intr  in  1  inter-processor interrupt level, mapped to IS[12]
- timer_pend  in  1  timer pending level (ungated by IE), mapped to IS[11]
- crmd_ie  in  1  current CRMD.IE
- csr_wen  in  1  CSR write strobe
- csr_waddr  in  `LSOC1K_CSR_BIT  CSR write address
- csr_wdata  in  `GRLEN  CSR write data
- csr_mask  in  `GRLEN  CSR write bit mask
- csr_raddr  in  `LSOC1K_CSR_BIT  CSR read address
- intr_rdata  out  `GRLEN  ECFG/ESTAT read data; 0 for any other address
- ecl_intr_ack  in  1  ecl accepts the request at an instruction boundary
- intr_req  out  1  interrupt request to ecl
- intr_vec  out  4  index of the winning IS bit, valid while intr_req and latched at ack
- intr_taken  out  1  one-cycle pulse in the cycle after an accepted handshake

Behaviour:
- Reset (resetn=0 at posedge): LIE=0, IS=0, FSM=IDLE, intr_req=0, intr_vec=0, intr_taken=0. Reset mid-handshake drops the request with no taken pulse.
- IS register update, every cycle:
  - IS[9:2] <= ext_intr, IS[11] <= timer_pend, IS[12] <= ipi_intr.
  - IS[1:0] are software bits, written only by an ESTAT write: new = (old & ~mask) | (wdata & mask) on bits 1:0.
  - Writes to any other ESTAT bit are ignored. IS[10]=0.
- LIE: masked write on ECFG, bits 12:0 except 10 (stuck 0). Upper bits read 0.
- intr_rdata:
  - ECFG: {19'b0, LIE}.
  - ESTAT: {19'b0, IS}, with ecode/esubcode fields reading 0.
  - A write and a read to the same register in one cycle reads the old value.
- Pending vector: pend = IS & LIE. Eligible = |pend & crmd_ie.
- Priority: the highest set index of pend wins (12 > 11 > 9..2 > 1 > 0). The result is registered into intr_vec.
- FSM:
  - IDLE: if eligible, go to REQ next cycle with intr_req=1 and intr_vec = winner.
  - REQ:
    - intr_req=1. intr_vec tracks the current winner each cycle, so a higher-priority arrival replaces it.
    - If ecl_intr_ack=1, latch intr_vec and go to TAKEN.
    - Else if not eligible (source dropped, LIE cleared or IE cleared), go to IDLE with intr_req=0.
    - Ack together with a same-cycle withdrawal condition: the ack wins.
  - TAKEN: intr_req=0, intr_taken=1 for exactly this cycle, intr_vec held. Go to HOLD.
  - HOLD: intr_req=0. When crmd_ie=0 is observed, go to IDLE. New requests require IE to be re-enabled (ertn or csrwr).
- Latency:
  - An ext_intr or timer edge at cycle N gives IS at N+1 and intr_req at N+2.
  - A software IS write at N gives intr_req at N+2.
  - ack at M gives intr_taken at M+1.
- ecl_intr_ack is ignored outside REQ.
- Sources are level-sensitive. Clearing is the source's responsibility; the timer is cleared via TICLR.

Optional Feature:
- Macro: INTR_SYNC_EN.
- Defined: ext_intr and ipi_intr pass through a 2-flop synchronizer (reset to 0) before IS. This adds 2 cycles: edge at N, IS at N+3, intr_req at N+4.
- Undefined: direct sampling as above.
- timer_pend and software bits are unaffected in both cases.

Test Plan:
- Reset, then LIE=0x800, crmd_ie=1, timer_pend=1 at cycle 10 -> intr_req=1 at cycle 12 with intr_vec=11. ack at 14 -> intr_taken pulse at 15. Drop crmd_ie at 16 -> FSM back in IDLE at 17.
- LIE=0x1FFF, ext_intr[0]=1 (IS bit 2) and ipi_intr=1 together -> intr_vec=12. Lower ipi_intr while in REQ -> intr_vec=2 two cycles later, intr_req stays 1.
- ESTAT write wdata=0x3, mask=0x1 with LIE=0x1 -> IS reads 0x1 and intr_req=1 two cycles after the write. Same write to bits 2+ -> bits unchanged.
- In REQ, clear LIE with no ack -> intr_req=0 the next cycle and no intr_taken. Repeat with ack in the same cycle as the LIE write -> intr_taken=1 next cycle.
- After TAKEN, keep crmd_ie=1 with the source still pending -> intr_req stays 0 (HOLD). Assert resetn=0 during REQ -> all outputs 0 next cycle.
- With INTR_SYNC_EN defined: ext_intr[7] edge at cycle 20 -> ESTAT bit 9 reads 1 at 23 and intr_req=1 at 24.
